// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Optional ARB_STARVE_GUARD_EN: a waiting fetch is granted after 3 data grants.
module mem_port_arbiter #(
   parameter int AW  = 16,
   parameter int DW  = 16,
   parameter int TMO = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_valid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_rd,
   input  logic          d_wr,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_valid,
   output logic [DW-1:0] d_rdata,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rdy,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          we_q;
   logic [7:0]    cnt_q;
   logic          d_req, busy, done, tmo_hit, fin;
   logic          grant_d, grant_i, fetch_first;

   assign d_req   = d_rd | d_wr;
   assign busy    = (state_q != IDLE);
   assign done    = busy & mem_rdy;
   assign tmo_hit = busy & ~mem_rdy & (cnt_q == TMO_LAST);
   assign fin     = done | tmo_hit;

`ifdef ARB_STARVE_GUARD_EN
   logic [1:0] starve_q;

   assign fetch_first = if_req & (starve_q == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_q <= 2'd0;
      else if (grant_i)
         starve_q <= 2'd0;
      else if (grant_d)
         starve_q <= if_req ? starve_q + 2'd1 : 2'd0;
   end
`else
   assign fetch_first = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = 1'b0;
      grant_i = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (d_req && !fetch_first) begin
               grant_d = 1'b1;
               state_d = DATA;
            end else if (if_req) begin
               grant_i = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH, DATA: begin
            if (fin)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         cnt_q    <= 8'd0;
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         if_rdata <= '0;
         d_rdata  <= '0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_d;
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         if (grant_d) begin
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            we_q    <= d_wr;
            cnt_q   <= 8'd0;
            if (d_rd & d_wr)
               err <= 1'b1;
         end else if (grant_i) begin
            addr_q <= if_addr;
            we_q   <= 1'b0;
            cnt_q  <= 8'd0;
         end else if (busy) begin
            cnt_q <= cnt_q + 8'd1;
         end
         if (tmo_hit)
            err <= 1'b1;
         // a timed-out access still completes, with zero data
         if (fin && state_q == FETCH) begin
            if_valid <= 1'b1;
            if_rdata <= done ? mem_rdata : '0;
         end
         if (fin && state_q == DATA) begin
            d_valid <= 1'b1;
            d_rdata <= done ? mem_rdata : '0;
         end
      end
   end

   assign mem_req   = busy;
   assign mem_we    = (state_q == DATA) & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign stall     = d_req & ~d_valid & rst_n;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps, then random transactions
// against a transaction-level model of grant order, latency and timeout.
module tb_mem_port_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_valid;
   logic [DW-1:0] if_rdata;
   logic          d_rd = 1'b0;
   logic          d_wr = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_valid;
   logic [DW-1:0] d_rdata;
   logic          stall;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_rdy = 1'b0;
   logic          err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_valid(if_valid), .if_rdata(if_rdata),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .err(err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      if_req = 1'b0;
      d_rd = 1'b0;
      d_wr = 1'b0;
      mem_rdy = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   int            nbusy;
   int            k, dly, nown, g;
   bit            has_f, has_d, both, wr, isd, tmo, err_exp;
   bit            own [2];
   logic [15:0]   fa, da, wd, rd, exp_rd;
   logic [AW-1:0] gaddr [4];

   initial begin
      // reset state
      rst_n = 1'b0;
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_valids", {if_valid, d_valid}, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", {if_rdata, d_rdata}, 0);
      do_reset();

      // minimum-latency fetch
      if_req = 1'b1;
      if_addr = 16'h0040;
      tick();
      chk("f_req", mem_req, 1);
      chk("f_addr", mem_addr, 16'h0040);
      chk("f_we", mem_we, 0);
      mem_rdy = 1'b1;
      mem_rdata = 16'hBEEF;
      tick();
      chk("f_valid", if_valid, 1);
      chk("f_rdata", if_rdata, 16'hBEEF);
      chk("f_err", err, 0);
      if_req = 1'b0;
      mem_rdy = 1'b0;
      tick();
      chk("f_pulse", if_valid, 0);
      chk("f_hold", if_rdata, 16'hBEEF);

      // simultaneous fetch and load: data first
      if_req = 1'b1;
      if_addr = 16'h0100;
      d_rd = 1'b1;
      d_addr = 16'h2000;
      tick();
      chk("p_daddr", mem_addr, 16'h2000);
      chk("p_stall", stall, 1);
      mem_rdy = 1'b1;
      mem_rdata = 16'h1111;
      tick();
      chk("p_dvalid", d_valid, 1);
      chk("p_drdata", d_rdata, 16'h1111);
      chk("p_stall0", stall, 0);
      d_rd = 1'b0;
      mem_rdy = 1'b0;
      tick();
      chk("p_faddr", mem_addr, 16'h0100);
      chk("p_freq", mem_req, 1);
      mem_rdy = 1'b1;
      mem_rdata = 16'h2222;
      tick();
      chk("p_fvalid", if_valid, 1);
      chk("p_frdata", if_rdata, 16'h2222);
      if_req = 1'b0;
      mem_rdy = 1'b0;
      tick();

      // store with delayed ready
      d_wr = 1'b1;
      d_addr = 16'h1234;
      d_wdata = 16'h5A5A;
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("w_req", mem_req, 1);
         chk("w_we", mem_we, 1);
         chk("w_addr", mem_addr, 16'h1234);
         chk("w_wdata", mem_wdata, 16'h5A5A);
         chk("w_early", d_valid, 0);
         if (i == 5)
            mem_rdy = 1'b1;
         tick();
      end
      chk("w_valid", d_valid, 1);
      d_wr = 1'b0;
      mem_rdy = 1'b0;
      tick();
      chk("w_pulse", d_valid, 0);

      // load that never gets ready
      d_rd = 1'b1;
      d_addr = 16'h0055;
      mem_rdata = 16'hFFFF;
      tick();
      nbusy = 0;
      for (int i = 0; i < 20; i++) begin
         if (!mem_req)
            break;
         nbusy++;
         tick();
      end
      chk("t_busy", nbusy, TMO);
      chk("t_valid", d_valid, 1);
      chk("t_rdata", d_rdata, 0);
      chk("t_err", err, 1);
      d_rd = 1'b0;
      tick();
      chk("t_sticky", err, 1);
      chk("t_pulse", d_valid, 0);

      // read and write together act as a write and flag err
      do_reset();
      d_rd = 1'b1;
      d_wr = 1'b1;
      d_addr = 16'h0077;
      d_wdata = 16'h0099;
      tick();
      chk("b_we", mem_we, 1);
      chk("b_err", err, 1);
      mem_rdy = 1'b1;
      tick();
      chk("b_valid", d_valid, 1);
      d_rd = 1'b0;
      d_wr = 1'b0;
      mem_rdy = 1'b0;
      tick();

      // reset in the middle of a data access
      d_rd = 1'b1;
      d_addr = 16'h0123;
      tick();
      chk("r_busy", mem_req, 1);
      rst_n = 1'b0;
      #1;
      chk("r_req", mem_req, 0);
      chk("r_stall", stall, 0);
      chk("r_addr", mem_addr, 0);
      chk("r_err", err, 0);
      d_rd = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("r_novalid", {d_valid, mem_req}, 0);
      end

      // random transactions against the model
      err_exp = 1'b0;
      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 2);
         has_f = (k != 1);
         has_d = (k != 0);
         both = has_d && ($urandom_range(0, 7) == 0);
         wr = both || ($urandom_range(0, 1) == 1);
         fa = 16'($urandom);
         da = 16'($urandom);
         wd = 16'($urandom);
         if_req = has_f;
         if_addr = fa;
         d_rd = has_d && (!wr || both);
         d_wr = has_d && wr;
         d_addr = da;
         d_wdata = wd;
         nown = 0;
         if (has_d) begin
            own[nown] = 1'b1;
            nown++;
         end
         if (has_f) begin
            own[nown] = 1'b0;
            nown++;
         end
         for (int o = 0; o < nown; o++) begin
            isd = own[o];
            dly = $urandom_range(0, 9);
            rd = 16'($urandom);
            tick();
            for (int c = 0; c < TMO; c++) begin
               chk("rnd_req", mem_req, 1);
               chk("rnd_addr", mem_addr, isd ? da : fa);
               chk("rnd_we", mem_we, isd && wr);
               if (isd) begin
                  chk("rnd_stall", stall, 1);
                  if (wr)
                     chk("rnd_wdata", mem_wdata, wd);
               end
               mem_rdata = rd;
               if (c == dly)
                  mem_rdy = 1'b1;
               tick();
               if (c == dly)
                  break;
            end
            mem_rdy = 1'b0;
            tmo = (dly >= TMO);
            exp_rd = tmo ? 16'h0 : rd;
            err_exp = err_exp | tmo | (isd && both);
            chk("rnd_valid", {d_valid, if_valid}, isd ? 2'b10 : 2'b01);
            chk("rnd_rdata", isd ? d_rdata : if_rdata, exp_rd);
            chk("rnd_err", err, err_exp);
            chk("rnd_stall0", stall, 0);
            if (isd) begin
               d_rd = 1'b0;
               d_wr = 1'b0;
            end else begin
               if_req = 1'b0;
            end
         end
         mem_rdy = 1'($urandom_range(0, 1));
         tick();
         chk("rnd_idle", {mem_req, d_valid, if_valid}, 0);
         mem_rdy = 1'b0;
      end

`ifdef ARB_STARVE_GUARD_EN
      // back-to-back loads must let a waiting fetch in
      do_reset();
      d_rd = 1'b1;
      d_addr = 16'hD000;
      if_req = 1'b1;
      if_addr = 16'hF000;
      mem_rdy = 1'b1;
      g = 0;
      for (int i = 0; i < 20; i++) begin
         if (g == 4)
            break;
         tick();
         if (mem_req) begin
            gaddr[g] = mem_addr;
            g++;
         end
      end
      chk("s_grants", g, 4);
      for (int i = 0; i < 3; i++)
         chk("s_data", gaddr[i], 16'hD000);
      chk("s_fetch", gaddr[3], 16'hF000);
      do_reset();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, address width.
REQ-002 SHALL have parameter DW, default 16, data width.
REQ-003 SHALL have parameter TMO, default 255, mem_rdy timeout in cycles (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port if_req  input  1  fetch request, held until if_valid.
REQ-007 SHALL have port if_addr  input  AW  fetch address.
REQ-008 SHALL have port if_valid  output  1  one-cycle pulse; if_rdata valid.
REQ-009 SHALL have port if_rdata  output  DW  fetched word.
REQ-010 SHALL have port d_rd / d_wr  input  1 each  data read (LD/POP) / write (ST/PUSH), held until d_valid.
REQ-011 SHALL have port d_addr / d_wdata  input  AW / DW  data address / store data.
REQ-012 SHALL have port d_valid  output  1  one-cycle pulse; access complete, d_rdata valid on reads.
REQ-013 SHALL have port d_rdata  output  DW  load data.
REQ-014 SHALL have port stall  output  1  pipeline hold while a data access is outstanding.
REQ-015 SHALL have port mem_req, mem_we  output  1 each  memory strobe, write enable.
REQ-016 SHALL have port mem_addr / mem_wdata  output  AW / DW  memory address / write data.
REQ-017 SHALL have port mem_rdata, mem_rdy  input  DW, 1  memory read data, completion.
REQ-018 SHALL have port err  output  1  sticky error (timeout or d_rd&d_wr).

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, DATA.
REQ-020 In IDLE, data request (d_rd|d_wr) SHALL win over if_req; transition to DATA or FETCH the next cycle.
REQ-021 On grant, address, wdata and we SHALL be latched; mem_* outputs SHALL be driven from the latches, stable while mem_req=1.
REQ-022 mem_req SHALL be 1 exactly in FETCH and DATA; mem_we=1 only in DATA for a write.
REQ-023 The cycle mem_rdy=1 in FETCH/DATA, mem_rdata SHALL be registered to if_rdata/d_rdata, the matching valid SHALL pulse the next cycle, FSM SHALL return to IDLE.
REQ-024 Minimum latency request->valid SHALL be 3 cycles (grant, mem_rdy same cycle as mem_req, valid).
REQ-025 mem_rdy in IDLE SHALL be ignored.
REQ-026 d_rd&d_wr both high SHALL be treated as write and SHALL set err.
REQ-027 A timeout counter SHALL clear on entering FETCH/DATA, increment each busy cycle; reaching TMO without mem_rdy SHALL set err, drop mem_req, return to IDLE, pulse the matching valid with rdata=0.
REQ-028 stall SHALL be (d_rd|d_wr) & ~d_valid, combinational.
REQ-029 if_rdata/d_rdata SHALL hold last value until next completion.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, all outputs 0, rdata registers 0, counters 0, err 0; in-flight access is abandoned with no valid pulse.

Configuration
REQ-031 Macro ARB_STARVE_GUARD_EN: when defined, a 2-bit counter SHALL count consecutive data grants while if_req is pending; at 3, next IDLE arbitration SHALL grant fetch and clear the counter; fetch grant also clears it.
REQ-032 Without ARB_STARVE_GUARD_EN, data SHALL always win (REQ-020), no counter logic.

Verification
REQ-033 if_req, addr 0x0040, mem_rdy high on first mem_req cycle, mem_rdata 0xBEEF -> if_valid at cycle 3, if_rdata 0xBEEF, err 0.
REQ-034 if_req and d_rd same cycle -> DATA granted first, stall 1 until d_valid, then FETCH; mem_addr shows d_addr before if_addr.
REQ-035 d_wr addr 0x1234 data 0x5A5A, mem_rdy delayed 5 cycles -> mem_we=1, mem_addr/mem_wdata stable 6 cycles, d_valid one pulse.
REQ-036 d_rd, mem_rdy never, TMO=8 -> mem_req drops after 8 busy cycles, err sticks 1, d_valid pulse with d_rdata 0.
REQ-037 rst_n low while in DATA -> outputs 0 same cycle, no d_valid; with ARB_STARVE_GUARD_EN, continuous d_rd plus if_req -> fetch granted after 3rd data grant.
